// File: rtl/fetch_stage.sv
// Instruction fetch: boot-vector load, two-word assembly, redirects, interrupt entry into IF/ID.
// Latency: one edge from fetch to IF/ID; two-word instructions issue after a one-slot bubble.
// Backpressure: stall holds PC, state and IF/ID; redirects override stall.
module fetch_stage #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       IMM_BIT    = 15,
    parameter logic [ADDR_W-1:0] BOOT_ADDR  = '0,
    parameter logic [ADDR_W-1:0] INT_VECTOR = 32'h0000_0002,
    parameter logic [15:0]       NOP        = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    input  logic              stall,
    input  logic              flush,
    input  logic              jump_taken,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              pc_load_mem,
    input  logic [ADDR_W-1:0] pc_mem_value,
    input  logic              interrupt_signal,
    output logic [15:0]       instruction_r,
    output logic [15:0]       immediate_r,
    output logic [ADDR_W-1:0] PC_r,
    output logic              interrupt_r,
    output logic              valid_r
);

    typedef enum logic [1:0] {
        BOOT_HI = 2'd0,
        BOOT_LO = 2'd1,
        RUN     = 2'd2,
        IMM     = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [15:0]       boot_hi, boot_hi_nxt;
    logic [15:0]       imm_word, imm_word_nxt;
    logic              int_pending, int_pending_nxt;
    logic              int_prev;

    logic [15:0]       ins_nxt, imm_nxt;
    logic [ADDR_W-1:0] pcr_nxt;
    logic              intr_nxt, vld_nxt;

    logic              int_rise, int_req;
    logic [ADDR_W-1:0] pc_inc;

    // A rising edge counts in the same cycle so the interrupted PC is the one being fetched.
    assign int_rise = interrupt_signal & ~int_prev;
    assign int_req  = int_pending | int_rise;
    assign pc_inc   = pc + ADDR_W'(1);

    always_comb begin
        imem_addr = pc;
        case (state)
            BOOT_HI: imem_addr = BOOT_ADDR;
            BOOT_LO: imem_addr = BOOT_ADDR + ADDR_W'(1);
            default: imem_addr = pc;
        endcase
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        boot_hi_nxt     = boot_hi;
        imm_word_nxt    = imm_word;
        int_pending_nxt = int_req;
        ins_nxt         = instruction_r;
        imm_nxt         = immediate_r;
        pcr_nxt         = PC_r;
        intr_nxt        = interrupt_r;
        vld_nxt         = valid_r;

        case (state)
            BOOT_HI: begin
                boot_hi_nxt = imem_data;
                state_nxt   = BOOT_LO;
            end
            BOOT_LO: begin
                pc_nxt    = ADDR_W'({boot_hi, imem_data});
                state_nxt = RUN;
            end
            default: begin
                if (pc_load_mem || jump_taken || flush) begin
                    // Any of these leaves a bubble and drops a half-fetched instruction.
                    ins_nxt   = NOP;
                    imm_nxt   = '0;
                    pcr_nxt   = '0;
                    intr_nxt  = 1'b0;
                    vld_nxt   = 1'b0;
                    state_nxt = RUN;
                    if (pc_load_mem) begin
                        pc_nxt = pc_mem_value;
                    end else if (jump_taken) begin
                        pc_nxt = jump_target;
                    end else if (state == RUN) begin
                        pc_nxt = pc_inc;
                    end
                end else if (stall) begin
                    state_nxt = state;
                end else if (state == IMM) begin
                    ins_nxt   = imm_word;
                    imm_nxt   = imem_data;
                    pcr_nxt   = pc_inc;
                    intr_nxt  = 1'b0;
                    vld_nxt   = 1'b1;
                    pc_nxt    = pc_inc;
                    state_nxt = RUN;
                end else if (int_req) begin
                    ins_nxt         = NOP;
                    imm_nxt         = '0;
                    pcr_nxt         = pc;
                    intr_nxt        = 1'b1;
                    vld_nxt         = 1'b1;
                    pc_nxt          = INT_VECTOR;
                    int_pending_nxt = 1'b0;
                end else if (imem_data[IMM_BIT]) begin
                    imm_word_nxt = imem_data;
                    ins_nxt      = NOP;
                    imm_nxt      = '0;
                    pcr_nxt      = '0;
                    intr_nxt     = 1'b0;
                    vld_nxt      = 1'b0;
                    pc_nxt       = pc_inc;
                    state_nxt    = IMM;
                end else begin
                    ins_nxt  = imem_data;
                    imm_nxt  = '0;
                    pcr_nxt  = pc_inc;
                    intr_nxt = 1'b0;
                    vld_nxt  = 1'b1;
                    pc_nxt   = pc_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= BOOT_HI;
            pc            <= '0;
            boot_hi       <= '0;
            imm_word      <= '0;
            int_pending   <= 1'b0;
            int_prev      <= 1'b0;
            instruction_r <= NOP;
            immediate_r   <= '0;
            PC_r          <= '0;
            interrupt_r   <= 1'b0;
            valid_r       <= 1'b0;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            boot_hi       <= boot_hi_nxt;
            imm_word      <= imm_word_nxt;
            int_pending   <= int_pending_nxt;
            int_prev      <= interrupt_signal;
            instruction_r <= ins_nxt;
            immediate_r   <= imm_nxt;
            PC_r          <= pcr_nxt;
            interrupt_r   <= intr_nxt;
            valid_r       <= vld_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, boot/async-reset sequences, randomized run vs reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall = 1'b0, flush = 1'b0, jmp = 1'b0, ld = 1'b0, irq = 1'b0;
    logic [31:0] jtgt = '0, ldv = '0;
    logic [15:0] instruction_r, immediate_r;
    logic [31:0] PC_r;
    logic        interrupt_r, valid_r;

    logic [15:0] mem [4096];
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[11:0]];

    fetch_stage dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .flush(flush), .jump_taken(jmp), .jump_target(jtgt),
        .pc_load_mem(ld), .pc_mem_value(ldv), .interrupt_signal(irq),
        .instruction_r(instruction_r), .immediate_r(immediate_r), .PC_r(PC_r),
        .interrupt_r(interrupt_r), .valid_r(valid_r)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    typedef struct {
        logic        stall, flush, jmp;
        logic [31:0] jtgt;
        logic        ld;
        logic [31:0] ldv;
        logic        irq;
        logic [31:0] e_addr;
        logic [15:0] e_ins, e_imm;
        logic [31:0] e_pcr;
        logic        e_int, e_vld;
    } vec_t;

    function automatic vec_t v(logic s, logic f, logic j, logic [31:0] jt, logic l, logic [31:0] lv,
                               logic i, logic [31:0] a, logic [15:0] ins, logic [15:0] imm,
                               logic [31:0] pcr, logic it, logic vl);
        vec_t r;
        r.stall = s; r.flush = f; r.jmp = j; r.jtgt = jt; r.ld = l; r.ldv = lv; r.irq = i;
        r.e_addr = a; r.e_ins = ins; r.e_imm = imm; r.e_pcr = pcr; r.e_int = it; r.e_vld = vl;
        return r;
    endfunction

    task automatic drive(input logic s, input logic f, input logic j, input logic [31:0] jt,
                         input logic l, input logic [31:0] lv, input logic i);
        stall = s; flush = f; jmp = j; jtgt = jt; ld = l; ldv = lv; irq = i;
    endtask

    task automatic chk_out(input string tag, input logic [15:0] ins, input logic [15:0] imm,
                           input logic [31:0] pcr, input logic it, input logic vl);
        chk({tag, ".instruction_r"}, 32'(instruction_r), 32'(ins));
        chk({tag, ".immediate_r"}, 32'(immediate_r), 32'(imm));
        chk({tag, ".interrupt_r"}, 32'(interrupt_r), 32'(it));
        chk({tag, ".valid_r"}, 32'(valid_r), 32'(vl));
        if (vl) chk({tag, ".PC_r"}, PC_r, pcr);
    endtask

    // Enter at negedge, leave at negedge with reset released.
    task automatic do_reset();
        reset = 1'b0;
        drive(0, 0, 0, '0, 0, '0, 0);
        #2;
        chk_out("reset", 16'h0, 16'h0, 32'h0, 1'b0, 1'b0);
        chk("reset.PC_r", PC_r, 32'h0);
        chk("reset.imem_addr", imem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Reference model: fetch cursor, pending half-instruction, pending interrupt.
    int          m_phase;  // 0/1 = loading boot halves, 2 = sequential, 3 = expecting immediate
    logic [31:0] m_pc;
    logic [15:0] m_hi, m_first;
    logic        m_pend, m_prev;
    logic [15:0] e_ins, e_imm;
    logic [31:0] e_pcr;
    logic        e_int, e_vld;

    function automatic logic [31:0] m_addr();
        if (m_phase == 0) return 32'h0;
        if (m_phase == 1) return 32'h1;
        return m_pc;
    endfunction

    task automatic m_slot(input logic [15:0] ins, input logic [15:0] imm, input logic [31:0] pcr,
                          input logic it, input logic vl);
        e_ins = ins; e_imm = imm; e_pcr = pcr; e_int = it; e_vld = vl;
    endtask

    task automatic model_reset();
        m_phase = 0; m_pc = 0; m_hi = 0; m_first = 0; m_pend = 0; m_prev = 0;
        m_slot(16'h0, 16'h0, 32'h0, 0, 0);
    endtask

    task automatic model_edge();
        logic [31:0] a;
        logic [15:0] w;
        logic        req;
        a = m_addr();
        w = mem[a[11:0]];
        req = m_pend || (irq && !m_prev);
        m_prev = irq;
        m_pend = req;
        if (m_phase == 0) begin
            m_hi = w; m_phase = 1;
        end else if (m_phase == 1) begin
            m_pc = {m_hi, w}; m_phase = 2;
        end else if (ld || jmp) begin
            m_pc = ld ? ldv : jtgt;
            m_slot(16'h0, 16'h0, 32'h0, 0, 0);
            m_phase = 2;
        end else if (flush) begin
            if (m_phase == 2) m_pc = m_pc + 1;
            m_slot(16'h0, 16'h0, 32'h0, 0, 0);
            m_phase = 2;
        end else if (stall) begin
            m_phase = m_phase;
        end else if (m_phase == 3) begin
            m_slot(m_first, w, m_pc + 1, 0, 1);
            m_pc = m_pc + 1;
            m_phase = 2;
        end else if (req) begin
            m_slot(16'h0, 16'h0, m_pc, 1, 1);
            m_pc = 32'h2;
            m_pend = 0;
        end else if (w[15]) begin
            m_first = w;
            m_pc = m_pc + 1;
            m_phase = 3;
            m_slot(16'h0, 16'h0, 32'h0, 0, 0);
        end else begin
            m_slot(w, 16'h0, m_pc + 1, 0, 1);
            m_pc = m_pc + 1;
        end
    endtask

    vec_t tbl[27];

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
        mem[1] = 16'h0010;  mem[2] = 16'h0002;  mem[3] = 16'h8C00;  mem[4] = 16'h0D0D;
        mem[12'h010] = 16'h1234; mem[12'h011] = 16'h8A00; mem[12'h012] = 16'hBEEF;
        mem[12'h013] = 16'h0111; mem[12'h014] = 16'h0222; mem[12'h040] = 16'h0440;
        mem[12'h100] = 16'h0100; mem[12'h101] = 16'h0101; mem[12'h102] = 16'h8E00;
        mem[12'h103] = 16'h0103; mem[12'hFFF] = 16'h0777;

        //            stl fl jmp jtgt          ld ldv     irq addr          ins      imm      pc_r          int vld
        tbl[0]  = v(0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,        16'h0,    16'h0,    32'h0,        0, 0);
        tbl[1]  = v(0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h1,        16'h0,    16'h0,    32'h0,        0, 0);
        tbl[2]  = v(0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h10,       16'h1234, 16'h0,    32'h11,       0, 1);
        tbl[3]  = v(0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h11,       16'h0,    16'h0,    32'h0,        0, 0);
        tbl[4]  = v(0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h12,       16'h8A00, 16'hBEEF, 32'h13,       0, 1);
        tbl[5]  = v(1, 0, 0, 32'h0,        0, 32'h0,   0, 32'h13,       16'h8A00, 16'hBEEF, 32'h13,       0, 1);
        tbl[6]  = v(1, 0, 0, 32'h0,        0, 32'h0,   0, 32'h13,       16'h8A00, 16'hBEEF, 32'h13,       0, 1);
        tbl[7]  = v(1, 0, 0, 32'h0,        0, 32'h0,   0, 32'h13,       16'h8A00, 16'hBEEF, 32'h13,       0, 1);
        tbl[8]  = v(0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h13,       16'h0111, 16'h0,    32'h14,       0, 1);
        tbl[9]  = v(0, 0, 0, 32'h0,        0, 32'h0,   1, 32'h14,       16'h0,    16'h0,    32'h14,       1, 1);
        tbl[10] = v(0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h2,        16'h0002, 16'h0,    32'h3,        0, 1);
        tbl[11] = v(0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h3,        16'h0,    16'h0,    32'h0,        0, 0);
        tbl[12] = v(0, 0, 0, 32'h0,        0, 32'h0,   1, 32'h4,        16'h8C00, 16'h0D0D, 32'h5,        0, 1);
        tbl[13] = v(0, 0, 0, 32'h0,        0, 32'h0,   1, 32'h5,        16'h0,    16'h0,    32'h5,        1, 1);
        tbl[14] = v(0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h2,        16'h0002, 16'h0,    32'h3,        0, 1);
        tbl[15] = v(0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h3,        16'h0,    16'h0,    32'h0,        0, 0);
        tbl[16] = v(1, 0, 1, 32'h40,       0, 32'h0,   0, 32'h4,        16'h0,    16'h0,    32'h0,        0, 0);
        tbl[17] = v(0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h40,       16'h0440, 16'h0,    32'h41,       0, 1);
        tbl[18] = v(0, 0, 1, 32'h80,       1, 32'h100, 0, 32'h41,       16'h0,    16'h0,    32'h0,        0, 0);
        tbl[19] = v(0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h100,      16'h0100, 16'h0,    32'h101,      0, 1);
        tbl[20] = v(0, 1, 0, 32'h0,        0, 32'h0,   0, 32'h101,      16'h0,    16'h0,    32'h0,        0, 0);
        tbl[21] = v(0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h102,      16'h0,    16'h0,    32'h0,        0, 0);
        tbl[22] = v(0, 1, 0, 32'h0,        0, 32'h0,   0, 32'h103,      16'h0,    16'h0,    32'h0,        0, 0);
        tbl[23] = v(0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h103,      16'h0103, 16'h0,    32'h104,      0, 1);
        tbl[24] = v(0, 0, 1, 32'hFFFFFFFF, 0, 32'h0,   0, 32'h104,      16'h0,    16'h0,    32'h0,        0, 0);
        tbl[25] = v(0, 0, 0, 32'h0,        0, 32'h0,   0, 32'hFFFFFFFF, 16'h0777, 16'h0,    32'h0,        0, 1);
        tbl[26] = v(0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,        16'h0000, 16'h0,    32'h1,        0, 1);

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].stall, tbl[i].flush, tbl[i].jmp, tbl[i].jtgt, tbl[i].ld, tbl[i].ldv, tbl[i].irq);
            #1;
            chk($sformatf("row%0d.imem_addr", i), imem_addr, tbl[i].e_addr);
            @(posedge clk);
            #1;
            chk_out($sformatf("row%0d", i), tbl[i].e_ins, tbl[i].e_imm, tbl[i].e_pcr, tbl[i].e_int, tbl[i].e_vld);
            @(negedge clk);
        end

        // Interrupt raised during boot stays pending and is taken at the first run cycle.
        do_reset();
        irq = 1'b1;
        @(negedge clk);
        irq = 1'b0;
        @(negedge clk);
        #1;
        chk("boot_int.imem_addr", imem_addr, 32'h10);
        @(posedge clk);
        #1;
        chk_out("boot_int", 16'h0, 16'h0, 32'h10, 1'b1, 1'b1);
        @(negedge clk);
        chk("boot_int.vector", imem_addr, 32'h2);
        @(posedge clk);
        #1;
        chk_out("after_int", 16'h0002, 16'h0, 32'h3, 1'b0, 1'b1);

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        #1;
        reset = 1'b0;
        #1;
        chk("async.valid_r", 32'(valid_r), 32'h0);
        chk("async.instruction_r", 32'(instruction_r), 32'h0);
        chk("async.PC_r", PC_r, 32'h0);
        chk("async.imem_addr", imem_addr, 32'h0);
        @(negedge clk);

        // Randomized run against the reference model.
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 16'($urandom);
            if ($urandom_range(0, 99) < 65) mem[i][15] = 1'b0;
        end
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] r;
            r = 32'($urandom_range(0, 99));
            stall = (r < 20);
            flush = ($urandom_range(0, 99) < 5);
            jmp   = ($urandom_range(0, 99) < 5);
            jtgt  = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 3)) : $urandom;
            ld    = ($urandom_range(0, 99) < 3);
            ldv   = $urandom;
            if ($urandom_range(0, 99) < 8) irq = ~irq;
            #1;
            chk("rnd.imem_addr", imem_addr, m_addr());
            model_edge();
            @(posedge clk);
            #1;
            chk_out("rnd", e_ins, e_imm, e_pcr, e_int, e_vld);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
